// File: rtl/dbram_pingpong_slave_pkg.sv
// Shared defaults for the dbram ping-pong slave slice.
package dbram_pingpong_slave_pkg;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 16;
endpackage

// File: rtl/dbram_pingpong_slave_if.sv
// Write/read bus for the ping-pong bank buffer; master = producer/consumer side.
interface dbram_pingpong_slave_if
    import dbram_pingpong_slave_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    // A write/commit takes effect only in a cycle where wr_ready=1, a read/done
    // only where rd_valid=1; attempts outside those cycles are dropped and flagged.
    logic                  wr_wen;
    logic [DATA_WIDTH-1:0] wr_din;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_commit;
    logic                  wr_ready;
    logic                  rd_valid;
    logic [ADDR_WIDTH:0]   rd_len;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_dout;
    logic                  rd_dout_valid;
    logic                  rd_done;
    logic                  err_overflow;
    logic                  err_underflow;

    modport master (
        output wr_wen, wr_din, wr_addr, wr_commit, rd_en, rd_addr, rd_done,
        input  wr_ready, rd_valid, rd_len, rd_dout, rd_dout_valid,
        input  err_overflow, err_underflow
    );

    modport slave (
        input  wr_wen, wr_din, wr_addr, wr_commit, rd_en, rd_addr, rd_done,
        output wr_ready, rd_valid, rd_len, rd_dout, rd_dout_valid,
        output err_overflow, err_underflow
    );
endinterface

// File: rtl/dbram_pingpong_slave_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with sync reset
// on the output register only.
module dbram_pingpong_slave_sdp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/dbram_pingpong_slave.sv
// Ping-pong bank buffer: producer fills one bank while the consumer reads the
// other; ownership moves via commit (writer->reader) and done (reader->writer).
module dbram_pingpong_slave
    import dbram_pingpong_slave_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    dbram_pingpong_slave_if.slave bus
);
    localparam int LW = ADDR_WIDTH + 1;

    logic [1:0]    full;
    logic          wsel;
    logic          rsel;
    logic [LW-1:0] len_q [2];
    logic          dout_valid_q;
    logic          err_ovf_q;
    logic          err_unf_q;

    logic          wr_fire;
    logic          commit_fire;
    logic          rd_fire;
    logic          done_fire;
    logic [LW-1:0] wr_len;

    assign bus.wr_ready      = !full[wsel];
    assign bus.rd_valid      = full[rsel];
    assign bus.rd_len        = len_q[rsel];
    assign bus.rd_dout_valid = dout_valid_q;
    assign bus.err_overflow  = err_ovf_q;
    assign bus.err_underflow = err_unf_q;

    assign wr_fire     = bus.wr_wen    && !full[wsel];
    assign commit_fire = bus.wr_commit && !full[wsel];
    assign rd_fire     = bus.rd_en     && full[rsel];
    assign done_fire   = bus.rd_done   && full[rsel];
    // Computed one bit wider so the last address yields 2**ADDR_WIDTH.
    assign wr_len      = {1'b0, bus.wr_addr} + LW'(1);

    // When wsel == rsel exactly one of (write side, read side) can fire, so the
    // len/full updates below never target the same bank from both sides.
    always_ff @(posedge clk) begin
        if (rst) begin
            full         <= 2'b00;
            wsel         <= 1'b0;
            rsel         <= 1'b0;
            len_q[0]     <= '0;
            len_q[1]     <= '0;
            dout_valid_q <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_unf_q    <= 1'b0;
        end else begin
            if (wr_fire && (wr_len > len_q[wsel])) begin
                len_q[wsel] <= wr_len;
            end
            if (done_fire) begin
                len_q[rsel] <= '0;
                full[rsel]  <= 1'b0;
                rsel        <= !rsel;
            end
            if (commit_fire) begin
                full[wsel] <= 1'b1;
                wsel       <= !wsel;
            end
            dout_valid_q <= rd_fire;
            if ((bus.wr_wen || bus.wr_commit) && full[wsel]) begin
                err_ovf_q <= 1'b1;
            end
            if ((bus.rd_en || bus.rd_done) && !full[rsel]) begin
                err_unf_q <= 1'b1;
            end
        end
    end

    dbram_pingpong_slave_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH + 1)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire),
        .waddr ({wsel, bus.wr_addr}),
        .wdata (bus.wr_din),
        .re    (rd_fire),
        .raddr ({rsel, bus.rd_addr}),
        .rdata (bus.rd_dout)
    );
endmodule

// File: tb/tb_dbram_pingpong_slave.sv
// Directed bench for dbram_pingpong_slave: bank hand-off, length tracking,
// error flags and reset behaviour.
module tb_dbram_pingpong_slave;
    localparam int DW = 8;
    localparam int AW = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [DW-1:0] exp_q[$];

    dbram_pingpong_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dbram_pingpong_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = !clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle();
        bus.wr_wen    = 1'b0;
        bus.wr_din    = '0;
        bus.wr_addr   = '0;
        bus.wr_commit = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        bus.rd_done   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic commit);
        bus.wr_wen    = 1'b1;
        bus.wr_addr   = addr;
        bus.wr_din    = data;
        bus.wr_commit = commit;
        step();
    endtask

    task automatic do_commit();
        bus.wr_commit = 1'b1;
        step();
    endtask

    task automatic do_done();
        bus.rd_done = 1'b1;
        step();
    endtask

    // Issues a read (optionally with done) and checks the data one cycle later.
    task automatic do_read(input string tag, input logic [AW-1:0] addr,
                           input logic [DW-1:0] exp, input logic done);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        bus.rd_done = done;
        exp_q.push_back(exp);
        step();
        check({tag, "_dv"}, 32'(bus.rd_dout_valid), 32'd1);
        check(tag, 32'(bus.rd_dout), 32'(exp_q.pop_front()));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd1);
        check({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
        check({tag, "_rd_len"}, 32'(bus.rd_len), 32'd0);
        check({tag, "_rd_dv"}, 32'(bus.rd_dout_valid), 32'd0);
        check({tag, "_rd_dout"}, 32'(bus.rd_dout), 32'd0);
        check({tag, "_err_ovf"}, 32'(bus.err_overflow), 32'd0);
        check({tag, "_err_unf"}, 32'(bus.err_underflow), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Fill bank0 with A0..A3, commit, read addr 2.
        for (int i = 0; i < 4; i++) do_write(AW'(i), DW'(8'hA0 + i), 1'b0);
        do_commit();
        check("b0_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("b0_rd_len", 32'(bus.rd_len), 32'd4);
        check("b0_wr_ready", 32'(bus.wr_ready), 32'd1);
        do_read("b0_rd_a2", AW'(2), 8'hA2, 1'b0);
        step();
        check("b0_dv_one_cycle", 32'(bus.rd_dout_valid), 32'd0);

        // Read bank0 while writing bank1 in the same cycle.
        bus.wr_wen  = 1'b1;
        bus.wr_addr = AW'(5);
        bus.wr_din  = 8'h55;
        do_read("b0_rd_a0_concurrent", AW'(0), 8'hA0, 1'b0);
        do_commit();
        do_done();
        check("b1_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("b1_rd_len", 32'(bus.rd_len), 32'd6);
        do_read("b1_rd_a5", AW'(5), 8'h55, 1'b0);

        // Both banks full: further write/commit dropped.
        do_write(AW'(0), 8'h11, 1'b1);
        check("full_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("pre_ovf", 32'(bus.err_overflow), 32'd0);
        do_write(AW'(5), 8'hEE, 1'b0);
        check("ovf_set", 32'(bus.err_overflow), 32'd1);
        do_commit();
        check("ovf_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("ovf_rd_len", 32'(bus.rd_len), 32'd6);
        do_read("ovf_rd_a5", AW'(5), 8'h55, 1'b0);
        do_done();
        check("b0b_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("b0b_rd_len", 32'(bus.rd_len), 32'd1);
        do_read("b0b_rd_a0", AW'(0), 8'h11, 1'b0);
        do_done();
        check("empty_rd_valid", 32'(bus.rd_valid), 32'd0);

        // Write + commit in the same cycle.
        do_write(AW'(7), 8'h77, 1'b1);
        check("wc_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("wc_rd_len", 32'(bus.rd_len), 32'd8);
        do_read("wc_rd_a7", AW'(7), 8'h77, 1'b0);

        // Top address write + commit while the reader releases the other bank.
        bus.rd_done = 1'b1;
        do_write({AW{1'b1}}, 8'h5A, 1'b1);
        check("top_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("top_rd_len", 32'(bus.rd_len), 32'd65536);
        check("top_wr_ready", 32'(bus.wr_ready), 32'd1);
        do_read("top_rd_done", {AW{1'b1}}, 8'h5A, 1'b1);
        check("top_released", 32'(bus.rd_valid), 32'd0);

        // Empty commit.
        do_commit();
        check("emptyc_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("emptyc_rd_len", 32'(bus.rd_len), 32'd0);
        do_done();

        // Underflow: done and read with nothing readable.
        check("pre_unf", 32'(bus.err_underflow), 32'd0);
        do_done();
        check("unf_set", 32'(bus.err_underflow), 32'd1);
        check("unf_rd_valid", 32'(bus.rd_valid), 32'd0);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(7);
        step();
        check("unf_dv", 32'(bus.rd_dout_valid), 32'd0);
        check("unf_dout_hold", 32'(bus.rd_dout), 32'h5A);

        // Reset mid-stream.
        do_write(AW'(3), 8'h33, 1'b1);
        check("pre_rst_rd_valid", 32'(bus.rd_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("midrst");

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
